// File: rtl/riscv_ifetch_pkg.sv
// Shared definitions for the RISC-V instruction fetch unit.
package riscv_ifetch_pkg;

  // 3-bit state encoding, same values as the original header
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_HOLD  = 3'd2,
    ST_FLUSH = 3'd3,
    ST_FAULT = 3'd4
  } ifetch_state_e;

  localparam int unsigned IFETCH_INSTR_BYTES = 4;
  localparam logic [31:0] IFETCH_RESET_PC    = 32'h0000_0000;

  // A fetch target must be word aligned
  function automatic logic ifetch_misaligned(input logic [31:0] addr);
    return (addr[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/riscv_ifetch_out_reg.sv
// Downstream holding register: instruction word, its PC and the valid flag.
module ifetch_out_reg
  import riscv_ifetch_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_load,
  input  logic        i_clear,
  input  logic [31:0] i_instr,
  input  logic [31:0] i_pc,
  input  logic        i_ready,
  output logic [31:0] o_instr,
  output logic [31:0] o_pc,
  output logic        o_valid
);

  logic [31:0] r_instr;
  logic [31:0] r_pc;
  logic        r_valid;

  // Load a fresh word, or drop valid on redirect or downstream handshake
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_instr <= '0;
      r_pc    <= '0;
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_instr <= i_instr;
      r_pc    <= i_pc;
      r_valid <= 1'b1;
    end else if (i_clear || (r_valid && i_ready)) begin
      r_valid <= 1'b0;
    end
  end

  assign o_instr = r_instr;
  assign o_pc    = r_pc;
  assign o_valid = r_valid;

endmodule

// File: rtl/riscv_ifetch.sv
// Instruction fetch unit: owns the PC, fetches over req/ack, handles redirects.
module riscv_ifetch
  import riscv_ifetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = IFETCH_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        fault
);

  ifetch_state_e r_state;
  logic [31:0]   r_pc;
  logic [31:0]   r_pend_pc;
  logic          r_fault;
  logic          r_pend_fault;

  logic          w_redir_bad;
  logic          w_load;
  logic          w_clear;
  logic          w_valid;

  assign w_redir_bad = ifetch_misaligned(redirect_pc);

  // Output register strobes decoded from state and handshake inputs
  always_comb begin
    w_load  = 1'b0;
    w_clear = 1'b0;
    if (r_state == ST_FETCH && imem_ack && !redirect) w_load = 1'b1;
    if (r_state == ST_HOLD && redirect) w_clear = 1'b1;
  end

  ifetch_out_reg u_out_reg (
    .i_clk   (clk),
    .i_rst_n (rst),
    .i_load  (w_load),
    .i_clear (w_clear),
    .i_instr (imem_rdata),
    .i_pc    (r_pc),
    .i_ready (instr_ready),
    .o_instr (instr),
    .o_pc    (instr_pc),
    .o_valid (w_valid)
  );

  // Fetch FSM with PC, pending redirect target and sticky fault
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_pc         <= RESET_PC;
      r_pend_pc    <= '0;
      r_fault      <= 1'b0;
      r_pend_fault <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: r_state <= ST_FETCH;

        ST_FETCH: begin
          if (redirect) begin
            if (imem_ack) begin
              if (w_redir_bad) begin
                r_fault <= 1'b1;
                r_state <= ST_FAULT;
              end else begin
                r_pc <= redirect_pc;
              end
            end else begin
              // request cannot be withdrawn: park the target until ack
              r_pend_pc <= redirect_pc;
              r_state   <= ST_FLUSH;
              if (w_redir_bad) begin
                r_fault      <= 1'b1;
                r_pend_fault <= 1'b1;
              end
            end
          end else if (imem_ack) begin
            r_pc    <= r_pc + 32'(IFETCH_INSTR_BYTES);
            r_state <= ST_HOLD;
          end
        end

        ST_HOLD: begin
          if (redirect) begin
            if (w_redir_bad) begin
              r_fault <= 1'b1;
              r_state <= ST_FAULT;
            end else begin
              r_pc    <= redirect_pc;
              r_state <= ST_FETCH;
            end
          end else if (w_valid && instr_ready) begin
            r_state <= ST_FETCH;
          end
        end

        ST_FLUSH: begin
          if (imem_ack) begin
            // a redirect in the ack cycle overrides the parked target
            if (r_pend_fault || (redirect && w_redir_bad)) begin
              r_fault <= 1'b1;
              r_state <= ST_FAULT;
            end else begin
              r_pc    <= redirect ? redirect_pc : r_pend_pc;
              r_state <= ST_FETCH;
            end
          end else if (redirect) begin
            r_pend_pc <= redirect_pc;
            if (w_redir_bad) begin
              r_fault      <= 1'b1;
              r_pend_fault <= 1'b1;
            end
          end
        end

        ST_FAULT: r_state <= ST_FAULT;

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign imem_req    = (r_state == ST_FETCH) || (r_state == ST_FLUSH);
  assign imem_addr   = r_pc;
  assign instr_valid = w_valid;
  assign fault       = r_fault;

endmodule

// File: tb/tb_riscv_ifetch.sv
// Directed scoreboard bench for riscv_ifetch.
module tb_riscv_ifetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        fault;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned n_fail   = 0;

  logic [31:0] exp_q[$];

  logic [31:0] slow_addr = 32'hFFFF_FFFF;
  int unsigned slow_lat  = 0;
  int unsigned wcnt      = 0;

  riscv_ifetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .fault       (fault)
  );

  always #5 clk = ~clk;

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    check1 ({tag, "_req"},   imem_req,    1'b0);
    check32({tag, "_addr"},  imem_addr,   32'h0);
    check32({tag, "_instr"}, instr,       32'h0);
    check32({tag, "_ipc"},   instr_pc,    32'h0);
    check1 ({tag, "_valid"}, instr_valid, 1'b0);
    check1 ({tag, "_fault"}, fault,       1'b0);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b0;
    redirect = 1'b0;
    redirect_pc = '0;
    #1;
    chk_reset({tag, "_async"});
    @(negedge clk);
    @(negedge clk);
    chk_reset({tag, "_held"});
  endtask

  task automatic chk_drained(input string tag);
    check32(tag, 32'(exp_q.size()), 32'h0);
  endtask

  // Instruction memory: acks after a per-address wait, data = addr >> 2
  always @(negedge clk) begin
    imem_ack = 1'b0;
    if (!rst || !imem_req) begin
      wcnt = 0;
    end else if (wcnt >= ((imem_addr == slow_addr) ? slow_lat : 0)) begin
      imem_ack   = 1'b1;
      imem_rdata = imem_addr >> 2;
      wcnt       = 0;
    end else begin
      wcnt++;
    end
  end

  // Scoreboard: every downstream handshake must match the next expected PC
  always @(negedge clk) begin
    logic [31:0] e;
    #3;
    if (rst && instr_valid && instr_ready) begin
      check1("sb_expected", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check32("sb_pc", instr_pc, e);
        check32("sb_instr", instr, e >> 2);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    #2;

    // S1: zero-wait stream, one instruction per two cycles
    slow_addr = 32'hFFFF_FFFF;
    instr_ready = 1'b1;
    do_reset("s1");
    exp_q.push_back(32'd0);
    exp_q.push_back(32'd4);
    exp_q.push_back(32'd8);
    exp_q.push_back(32'd12);
    #1 rst = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      check1("s1_req", imem_req, 1'(k % 2));
      check1("s1_valid", instr_valid, 1'((k + 1) % 2));
      if (k % 2 == 1) check32("s1_addr", imem_addr, 32'((k - 1) * 2));
      else            check32("s1_ipc", instr_pc, 32'((k - 2) * 2));
    end
    #1 instr_ready = 1'b0;
    @(negedge clk);
    check1("s1_hold_valid", instr_valid, 1'b1);
    check32("s1_hold_pc", instr_pc, 32'd16);
    chk_drained("s1_drained");

    // S2: slow fetch at 8, redirect to 32 in the first wait cycle
    slow_addr = 32'd8;
    slow_lat = 2;
    instr_ready = 1'b1;
    do_reset("s2");
    exp_q.push_back(32'd0);
    exp_q.push_back(32'd4);
    exp_q.push_back(32'd32);
    #1 rst = 1'b1;
    repeat (5) @(negedge clk);
    check1("s2_req_w0", imem_req, 1'b1);
    check32("s2_addr_w0", imem_addr, 32'd8);
    #1 redirect = 1'b1; redirect_pc = 32'd32;
    @(negedge clk);
    check32("s2_addr_w1", imem_addr, 32'd8);
    check1("s2_valid_w1", instr_valid, 1'b0);
    #1 redirect = 1'b0;
    @(negedge clk);
    check32("s2_addr_w2", imem_addr, 32'd8);
    check1("s2_valid_w2", instr_valid, 1'b0);
    @(negedge clk);
    check32("s2_addr_new", imem_addr, 32'd32);
    check1("s2_valid_drop", instr_valid, 1'b0);
    @(negedge clk);
    check1("s2_valid", instr_valid, 1'b1);
    check32("s2_ipc", instr_pc, 32'd32);
    @(negedge clk);
    #1 instr_ready = 1'b0;
    @(negedge clk);
    chk_drained("s2_drained");

    // S3: stalled in HOLD at 20, redirect to 0
    slow_addr = 32'hFFFF_FFFF;
    instr_ready = 1'b1;
    do_reset("s3");
    for (int i = 0; i < 5; i++) exp_q.push_back(32'(i * 4));
    #1 rst = 1'b1;
    repeat (11) @(negedge clk);
    #1 instr_ready = 1'b0;
    @(negedge clk);
    check1("s3_hold_valid", instr_valid, 1'b1);
    check32("s3_hold_pc", instr_pc, 32'd20);
    @(negedge clk);
    check1("s3_hold_valid2", instr_valid, 1'b1);
    #1 redirect = 1'b1; redirect_pc = 32'd0;
    @(negedge clk);
    check1("s3_valid_drop", instr_valid, 1'b0);
    check32("s3_addr", imem_addr, 32'd0);
    #1 redirect = 1'b0; instr_ready = 1'b1; exp_q.push_back(32'd0);
    @(negedge clk);
    check1("s3_valid", instr_valid, 1'b1);
    check32("s3_ipc", instr_pc, 32'd0);
    @(negedge clk);
    #1 instr_ready = 1'b0;
    @(negedge clk);
    chk_drained("s3_drained");

    // S4: two redirects while flushing, last one wins
    slow_addr = 32'd0;
    slow_lat = 4;
    instr_ready = 1'b1;
    do_reset("s4");
    exp_q.push_back(32'd60);
    #1 rst = 1'b1;
    @(negedge clk);
    check32("s4_addr0", imem_addr, 32'd0);
    #1 redirect = 1'b1; redirect_pc = 32'd40;
    @(negedge clk);
    check1("s4_req_flush", imem_req, 1'b1);
    #1 redirect_pc = 32'd60;
    @(negedge clk);
    check32("s4_addr_flush", imem_addr, 32'd0);
    #1 redirect = 1'b0;
    repeat (3) @(negedge clk);
    check32("s4_addr_new", imem_addr, 32'd60);
    check1("s4_valid_drop", instr_valid, 1'b0);
    @(negedge clk);
    check1("s4_valid", instr_valid, 1'b1);
    check32("s4_ipc", instr_pc, 32'd60);
    @(negedge clk);
    #1 instr_ready = 1'b0;
    @(negedge clk);
    chk_drained("s4_drained");

    // S4b: redirect in the flush ack cycle overrides the parked target
    slow_addr = 32'd0;
    slow_lat = 2;
    instr_ready = 1'b1;
    do_reset("s4b");
    exp_q.push_back(32'd80);
    #1 rst = 1'b1;
    @(negedge clk);
    #1 redirect = 1'b1; redirect_pc = 32'd40;
    @(negedge clk);
    #1 redirect = 1'b0;
    @(negedge clk);
    #1 redirect = 1'b1; redirect_pc = 32'd80;
    @(negedge clk);
    check32("s4b_addr", imem_addr, 32'd80);
    #1 redirect = 1'b0;
    @(negedge clk);
    check32("s4b_ipc", instr_pc, 32'd80);
    @(negedge clk);
    #1 instr_ready = 1'b0;
    @(negedge clk);
    chk_drained("s4b_drained");

    // S5: misaligned redirect from HOLD, fault is sticky
    slow_addr = 32'hFFFF_FFFF;
    instr_ready = 1'b0;
    do_reset("s5");
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    check1("s5_valid_hold", instr_valid, 1'b1);
    check1("s5_fault_pre", fault, 1'b0);
    #1 redirect = 1'b1; redirect_pc = 32'h0000_0006;
    @(negedge clk);
    check1("s5_fault", fault, 1'b1);
    check1("s5_req", imem_req, 1'b0);
    check1("s5_valid", instr_valid, 1'b0);
    #1 redirect_pc = 32'd8; instr_ready = 1'b1;
    repeat (3) @(negedge clk);
    check1("s5_fault_stay", fault, 1'b1);
    check1("s5_req_stay", imem_req, 1'b0);
    check1("s5_valid_stay", instr_valid, 1'b0);
    #1 instr_ready = 1'b0;

    // S5b: misaligned redirect while a fetch is outstanding
    slow_addr = 32'd0;
    slow_lat = 2;
    do_reset("s5b");
    #1 rst = 1'b1;
    @(negedge clk);
    #1 redirect = 1'b1; redirect_pc = 32'h0000_0006;
    @(negedge clk);
    check1("s5b_fault", fault, 1'b1);
    check1("s5b_req_flush", imem_req, 1'b1);
    #1 redirect = 1'b0;
    @(negedge clk);
    check1("s5b_req_ack", imem_req, 1'b1);
    @(negedge clk);
    check1("s5b_req_fault", imem_req, 1'b0);
    check1("s5b_valid", instr_valid, 1'b0);
    check1("s5b_fault_stay", fault, 1'b1);

    // S6: reset asserted mid-request at pc 12
    slow_addr = 32'd12;
    slow_lat = 5;
    instr_ready = 1'b1;
    do_reset("s6");
    exp_q.push_back(32'd0);
    exp_q.push_back(32'd4);
    exp_q.push_back(32'd8);
    #1 rst = 1'b1;
    repeat (7) @(negedge clk);
    check1("s6_req_pre", imem_req, 1'b1);
    check32("s6_addr_pre", imem_addr, 32'd12);
    #1 rst = 1'b0;
    #1 chk_reset("s6_mid");
    slow_addr = 32'hFFFF_FFFF;
    @(negedge clk);
    chk_drained("s6_drained_a");
    exp_q.push_back(32'd0);
    #1 rst = 1'b1;
    @(negedge clk);
    check1("s6_req_post", imem_req, 1'b1);
    check32("s6_addr_post", imem_addr, 32'd0);
    @(negedge clk);
    check32("s6_ipc_post", instr_pc, 32'd0);
    @(negedge clk);
    #1 instr_ready = 1'b0;
    @(negedge clk);
    chk_drained("s6_drained_b");

    // S7: PC wraps from 0xFFFF_FFFC to 0
    instr_ready = 1'b0;
    do_reset("s7");
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    #1 redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    @(negedge clk);
    check32("s7_addr_top", imem_addr, 32'hFFFF_FFFC);
    #1 redirect = 1'b0; instr_ready = 1'b1;
    exp_q.push_back(32'hFFFF_FFFC);
    exp_q.push_back(32'h0000_0000);
    @(negedge clk);
    check32("s7_ipc_top", instr_pc, 32'hFFFF_FFFC);
    @(negedge clk);
    check32("s7_addr_wrap", imem_addr, 32'h0);
    @(negedge clk);
    check32("s7_ipc_wrap", instr_pc, 32'h0);
    @(negedge clk);
    #1 instr_ready = 1'b0;
    @(negedge clk);
    chk_drained("s7_drained");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
